// File: rtl/snf_link_rxreq_wrap.sv
// CHI-E REQ link receiver at the SN-F: grants L-credits sized to a flit FIFO, queues REQ flits and
// presents decoded head fields to the request tracker. Optional TgtID check: SNF_RXREQ_TGTID_CHK_EN.
`ifndef CHIE_REQ_FLIT_WIDTH
`define CHIE_REQ_FLIT_WIDTH              133
`define CHIE_REQ_FLIT_QOS_WIDTH          4
`define CHIE_REQ_FLIT_QOS_LSB            0
`define CHIE_REQ_FLIT_TGTID_WIDTH        11
`define CHIE_REQ_FLIT_TGTID_LSB          4
`define CHIE_REQ_FLIT_SRCID_WIDTH        11
`define CHIE_REQ_FLIT_SRCID_LSB          15
`define CHIE_REQ_FLIT_TXNID_WIDTH        12
`define CHIE_REQ_FLIT_TXNID_LSB          26
`define CHIE_REQ_FLIT_RETURNNID_WIDTH    11
`define CHIE_REQ_FLIT_RETURNNID_LSB      38
`define CHIE_REQ_FLIT_RETURNTXNID_WIDTH  12
`define CHIE_REQ_FLIT_RETURNTXNID_LSB    49
`define CHIE_REQ_FLIT_OPCODE_WIDTH       7
`define CHIE_REQ_FLIT_OPCODE_LSB         61
`define CHIE_REQ_FLIT_SIZE_WIDTH         3
`define CHIE_REQ_FLIT_SIZE_LSB           68
`define CHIE_REQ_FLIT_ADDR_WIDTH         52
`define CHIE_REQ_FLIT_ADDR_LSB           71
`define CHIE_REQ_FLIT_NS_WIDTH           1
`define CHIE_REQ_FLIT_NS_LSB             123
`define CHIE_REQ_FLIT_ALLOWRETRY_WIDTH   1
`define CHIE_REQ_FLIT_ALLOWRETRY_LSB     124
`define CHIE_REQ_FLIT_ORDER_WIDTH        2
`define CHIE_REQ_FLIT_ORDER_LSB          125
`define CHIE_REQ_FLIT_MEMATTR_WIDTH      4
`define CHIE_REQ_FLIT_MEMATTR_LSB        127
`define CHIE_REQ_FLIT_DODWT_WIDTH        1
`define CHIE_REQ_FLIT_DODWT_LSB          131
`define CHIE_REQ_FLIT_TRACETAG_WIDTH     1
`define CHIE_REQ_FLIT_TRACETAG_LSB       132
`endif

module snf_link_rxreq_wrap #(
  parameter int SNF_NID_PARAM    = 0,
  parameter int RXREQ_FIFO_DEPTH = 4,
  parameter int RXREQ_CNT_WIDTH  = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rxreqflitv,
  input  logic [`CHIE_REQ_FLIT_WIDTH-1:0]           rxreqflit,
  input  logic                                      rxreqflitpend,
  output logic                                      rxreq_lcrdv,
  output logic                                      rxreq_valid,
  input  logic                                      rxreq_ready,
  output logic [`CHIE_REQ_FLIT_OPCODE_WIDTH-1:0]      rxreq_opcode,
  output logic [`CHIE_REQ_FLIT_TXNID_WIDTH-1:0]       rxreq_txnid,
  output logic [`CHIE_REQ_FLIT_SRCID_WIDTH-1:0]       rxreq_srcid,
  output logic [`CHIE_REQ_FLIT_RETURNNID_WIDTH-1:0]   rxreq_returnnid,
  output logic [`CHIE_REQ_FLIT_RETURNTXNID_WIDTH-1:0] rxreq_returntxnid,
  output logic [`CHIE_REQ_FLIT_SIZE_WIDTH-1:0]        rxreq_size,
  output logic [`CHIE_REQ_FLIT_ADDR_WIDTH-1:0]        rxreq_addr,
  output logic [`CHIE_REQ_FLIT_NS_WIDTH-1:0]          rxreq_ns,
  output logic [`CHIE_REQ_FLIT_QOS_WIDTH-1:0]         rxreq_qos,
  output logic [`CHIE_REQ_FLIT_ORDER_WIDTH-1:0]       rxreq_order,
  output logic [`CHIE_REQ_FLIT_MEMATTR_WIDTH-1:0]     rxreq_memattr,
  output logic [`CHIE_REQ_FLIT_ALLOWRETRY_WIDTH-1:0]  rxreq_allowretry,
  output logic [`CHIE_REQ_FLIT_DODWT_WIDTH-1:0]       rxreq_dodwt,
  output logic [`CHIE_REQ_FLIT_TRACETAG_WIDTH-1:0]    rxreq_tracetag,
  output logic                                      rxreq_err
);
  typedef struct packed {
    logic [`CHIE_REQ_FLIT_OPCODE_WIDTH-1:0]      opcode;
    logic [`CHIE_REQ_FLIT_TXNID_WIDTH-1:0]       txnid;
    logic [`CHIE_REQ_FLIT_SRCID_WIDTH-1:0]       srcid;
    logic [`CHIE_REQ_FLIT_RETURNNID_WIDTH-1:0]   returnnid;
    logic [`CHIE_REQ_FLIT_RETURNTXNID_WIDTH-1:0] returntxnid;
    logic [`CHIE_REQ_FLIT_SIZE_WIDTH-1:0]        size;
    logic [`CHIE_REQ_FLIT_ADDR_WIDTH-1:0]        addr;
    logic [`CHIE_REQ_FLIT_NS_WIDTH-1:0]          ns;
    logic [`CHIE_REQ_FLIT_QOS_WIDTH-1:0]         qos;
    logic [`CHIE_REQ_FLIT_ORDER_WIDTH-1:0]       order;
    logic [`CHIE_REQ_FLIT_MEMATTR_WIDTH-1:0]     memattr;
    logic [`CHIE_REQ_FLIT_ALLOWRETRY_WIDTH-1:0]  allowretry;
    logic [`CHIE_REQ_FLIT_DODWT_WIDTH-1:0]       dodwt;
    logic [`CHIE_REQ_FLIT_TRACETAG_WIDTH-1:0]    tracetag;
  } req_fields_t;

  localparam int CW  = RXREQ_CNT_WIDTH;
  localparam int CW1 = CW + 1;
  localparam int PW  = (RXREQ_FIFO_DEPTH > 1) ? $clog2(RXREQ_FIFO_DEPTH) : 1;
  localparam logic [PW-1:0]  LAST    = PW'(RXREQ_FIFO_DEPTH - 1);
  localparam logic [CW1-1:0] DEPTH_C = CW1'(RXREQ_FIFO_DEPTH);

  logic [CW-1:0] crd_out_q, fifo_cnt_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  req_fields_t   mem [RXREQ_FIFO_DEPTH];
  req_fields_t   in_f, out_f;
  logic          grant_s0, flit_acc, is_crd_ret, tgt_bad, push, pop, err_d;
  logic          unused_ok;

  always_comb begin
    in_f             = '0;
    in_f.opcode      = rxreqflit[`CHIE_REQ_FLIT_OPCODE_LSB +: `CHIE_REQ_FLIT_OPCODE_WIDTH];
    in_f.txnid       = rxreqflit[`CHIE_REQ_FLIT_TXNID_LSB +: `CHIE_REQ_FLIT_TXNID_WIDTH];
    in_f.srcid       = rxreqflit[`CHIE_REQ_FLIT_SRCID_LSB +: `CHIE_REQ_FLIT_SRCID_WIDTH];
    in_f.returnnid   = rxreqflit[`CHIE_REQ_FLIT_RETURNNID_LSB +: `CHIE_REQ_FLIT_RETURNNID_WIDTH];
    in_f.returntxnid = rxreqflit[`CHIE_REQ_FLIT_RETURNTXNID_LSB +: `CHIE_REQ_FLIT_RETURNTXNID_WIDTH];
    in_f.size        = rxreqflit[`CHIE_REQ_FLIT_SIZE_LSB +: `CHIE_REQ_FLIT_SIZE_WIDTH];
    in_f.addr        = rxreqflit[`CHIE_REQ_FLIT_ADDR_LSB +: `CHIE_REQ_FLIT_ADDR_WIDTH];
    in_f.ns          = rxreqflit[`CHIE_REQ_FLIT_NS_LSB +: `CHIE_REQ_FLIT_NS_WIDTH];
    in_f.qos         = rxreqflit[`CHIE_REQ_FLIT_QOS_LSB +: `CHIE_REQ_FLIT_QOS_WIDTH];
    in_f.order       = rxreqflit[`CHIE_REQ_FLIT_ORDER_LSB +: `CHIE_REQ_FLIT_ORDER_WIDTH];
    in_f.memattr     = rxreqflit[`CHIE_REQ_FLIT_MEMATTR_LSB +: `CHIE_REQ_FLIT_MEMATTR_WIDTH];
    in_f.allowretry  = rxreqflit[`CHIE_REQ_FLIT_ALLOWRETRY_LSB +: `CHIE_REQ_FLIT_ALLOWRETRY_WIDTH];
    in_f.dodwt       = rxreqflit[`CHIE_REQ_FLIT_DODWT_LSB +: `CHIE_REQ_FLIT_DODWT_WIDTH];
    in_f.tracetag    = rxreqflit[`CHIE_REQ_FLIT_TRACETAG_LSB +: `CHIE_REQ_FLIT_TRACETAG_WIDTH];
  end

`ifdef SNF_RXREQ_TGTID_CHK_EN
  localparam logic [`CHIE_REQ_FLIT_TGTID_WIDTH-1:0] MY_NID = `CHIE_REQ_FLIT_TGTID_WIDTH'(SNF_NID_PARAM);
  assign tgt_bad = rxreqflit[`CHIE_REQ_FLIT_TGTID_LSB +: `CHIE_REQ_FLIT_TGTID_WIDTH] != MY_NID;
`else
  assign tgt_bad = 1'b0;
`endif
  assign unused_ok = ^{rxreqflitpend, rxreqflit, SNF_NID_PARAM};

  // Registered counts only: a same-cycle pop frees its slot for grant one cycle later.
  assign grant_s0   = ~rst & (({1'b0, crd_out_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
  assign flit_acc   = rxreqflitv & (crd_out_q != '0);
  assign is_crd_ret = (in_f.opcode == '0);
  assign push       = flit_acc & ~is_crd_ret & ~tgt_bad;
  assign rxreq_valid = (fifo_cnt_q != '0);
  assign pop        = rxreq_valid & rxreq_ready;
  assign err_d      = (rxreqflitv & (crd_out_q == '0)) | (flit_acc & tgt_bad);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxreq_lcrdv <= 1'b0;
      rxreq_err   <= 1'b0;
      crd_out_q   <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < RXREQ_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      rxreq_lcrdv <= grant_s0;
      rxreq_err   <= err_d;
      crd_out_q   <= crd_out_q + CW'(grant_s0) - CW'(flit_acc);
      if (push) begin
        mem[wr_ptr] <= in_f;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign out_f = rxreq_valid ? mem[rd_ptr] : '0;

  assign rxreq_opcode      = out_f.opcode;
  assign rxreq_txnid       = out_f.txnid;
  assign rxreq_srcid       = out_f.srcid;
  assign rxreq_returnnid   = out_f.returnnid;
  assign rxreq_returntxnid = out_f.returntxnid;
  assign rxreq_size        = out_f.size;
  assign rxreq_addr        = out_f.addr;
  assign rxreq_ns          = out_f.ns;
  assign rxreq_qos         = out_f.qos;
  assign rxreq_order       = out_f.order;
  assign rxreq_memattr     = out_f.memattr;
  assign rxreq_allowretry  = out_f.allowretry;
  assign rxreq_dodwt       = out_f.dodwt;
  assign rxreq_tracetag    = out_f.tracetag;

endmodule

// File: tb/tb_snf_link_rxreq_wrap.sv
// Self-checking bench for snf_link_rxreq_wrap: credit-following sender plus an in-order scoreboard.
`ifndef CHIE_REQ_FLIT_WIDTH
`define CHIE_REQ_FLIT_WIDTH              133
`define CHIE_REQ_FLIT_QOS_WIDTH          4
`define CHIE_REQ_FLIT_QOS_LSB            0
`define CHIE_REQ_FLIT_TGTID_WIDTH        11
`define CHIE_REQ_FLIT_TGTID_LSB          4
`define CHIE_REQ_FLIT_SRCID_WIDTH        11
`define CHIE_REQ_FLIT_SRCID_LSB          15
`define CHIE_REQ_FLIT_TXNID_WIDTH        12
`define CHIE_REQ_FLIT_TXNID_LSB          26
`define CHIE_REQ_FLIT_RETURNNID_WIDTH    11
`define CHIE_REQ_FLIT_RETURNNID_LSB      38
`define CHIE_REQ_FLIT_RETURNTXNID_WIDTH  12
`define CHIE_REQ_FLIT_RETURNTXNID_LSB    49
`define CHIE_REQ_FLIT_OPCODE_WIDTH       7
`define CHIE_REQ_FLIT_OPCODE_LSB         61
`define CHIE_REQ_FLIT_SIZE_WIDTH         3
`define CHIE_REQ_FLIT_SIZE_LSB           68
`define CHIE_REQ_FLIT_ADDR_WIDTH         52
`define CHIE_REQ_FLIT_ADDR_LSB           71
`define CHIE_REQ_FLIT_NS_WIDTH           1
`define CHIE_REQ_FLIT_NS_LSB             123
`define CHIE_REQ_FLIT_ALLOWRETRY_WIDTH   1
`define CHIE_REQ_FLIT_ALLOWRETRY_LSB     124
`define CHIE_REQ_FLIT_ORDER_WIDTH        2
`define CHIE_REQ_FLIT_ORDER_LSB          125
`define CHIE_REQ_FLIT_MEMATTR_WIDTH      4
`define CHIE_REQ_FLIT_MEMATTR_LSB        127
`define CHIE_REQ_FLIT_DODWT_WIDTH        1
`define CHIE_REQ_FLIT_DODWT_LSB          131
`define CHIE_REQ_FLIT_TRACETAG_WIDTH     1
`define CHIE_REQ_FLIT_TRACETAG_LSB       132
`endif

module tb_snf_link_rxreq_wrap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxreqflitv = 1'b0;
  logic [`CHIE_REQ_FLIT_WIDTH-1:0] rxreqflit = '0;
  logic rxreqflitpend = 1'b0;
  logic rxreq_ready = 1'b0;
  logic rxreq_lcrdv, rxreq_valid, rxreq_err;
  logic [6:0]  rxreq_opcode;
  logic [11:0] rxreq_txnid, rxreq_returntxnid;
  logic [10:0] rxreq_srcid, rxreq_returnnid;
  logic [2:0]  rxreq_size;
  logic [51:0] rxreq_addr;
  logic        rxreq_ns, rxreq_allowretry, rxreq_dodwt, rxreq_tracetag;
  logic [3:0]  rxreq_qos, rxreq_memattr;
  logic [1:0]  rxreq_order;

  typedef struct packed {
    logic [6:0]  op;
    logic [11:0] txn;
    logic [10:0] src;
    logic [51:0] addr;
    logic [3:0]  qos;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, tb_crd = 0, pops = 0, err_seen = 0;

  always #5 clk = ~clk;

  snf_link_rxreq_wrap dut (
    .clk(clk), .rst(rst), .rxreqflitv(rxreqflitv), .rxreqflit(rxreqflit),
    .rxreqflitpend(rxreqflitpend), .rxreq_lcrdv(rxreq_lcrdv), .rxreq_valid(rxreq_valid),
    .rxreq_ready(rxreq_ready), .rxreq_opcode(rxreq_opcode), .rxreq_txnid(rxreq_txnid),
    .rxreq_srcid(rxreq_srcid), .rxreq_returnnid(rxreq_returnnid),
    .rxreq_returntxnid(rxreq_returntxnid), .rxreq_size(rxreq_size), .rxreq_addr(rxreq_addr),
    .rxreq_ns(rxreq_ns), .rxreq_qos(rxreq_qos), .rxreq_order(rxreq_order),
    .rxreq_memattr(rxreq_memattr), .rxreq_allowretry(rxreq_allowretry),
    .rxreq_dodwt(rxreq_dodwt), .rxreq_tracetag(rxreq_tracetag), .rxreq_err(rxreq_err)
  );

  function automatic logic [`CHIE_REQ_FLIT_WIDTH-1:0] mk_flit(logic [6:0] op, logic [11:0] txn,
                                                             logic [51:0] addr);
    logic [`CHIE_REQ_FLIT_WIDTH-1:0] f;
    f = '0;
    f[`CHIE_REQ_FLIT_OPCODE_LSB +: 7] = op;
    f[`CHIE_REQ_FLIT_TXNID_LSB +: 12] = txn;
    f[`CHIE_REQ_FLIT_SRCID_LSB +: 11] = txn[10:0] + 11'h5;
    f[`CHIE_REQ_FLIT_ADDR_LSB +: 52]  = addr;
    f[`CHIE_REQ_FLIT_QOS_LSB +: 4]    = txn[3:0];
    f[`CHIE_REQ_FLIT_SIZE_LSB +: 3]   = 3'd6;
    return f;
  endfunction

  // Drive a credited flit; non-credit-return flits are expected at the output in order.
  task automatic drive_flit(logic [6:0] op, logic [11:0] txn, logic [51:0] addr);
    rxreqflitv = 1'b1;
    rxreqflit  = mk_flit(op, txn, addr);
    tb_crd--;
    if (op != 7'h00) sb.push_back('{op: op, txn: txn, src: txn[10:0] + 11'h5, addr: addr, qos: txn[3:0]});
  endtask

  // One cycle: observe at negedge (credits, errors, handshakes), then advance past the posedge.
  task automatic step();
    exp_t e, a;
    @(negedge clk);
    if (rxreq_lcrdv === 1'b1) tb_crd++;
    if (rxreq_err === 1'b1) err_seen++;
    if (rxreq_valid === 1'b1 && rxreq_ready === 1'b1) begin
      pops++;
      total++;
      a = '{op: rxreq_opcode, txn: rxreq_txnid, src: rxreq_srcid, addr: rxreq_addr, qos: rxreq_qos};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: unexpected entry txnid=%0h, scoreboard empty", rxreq_txnid);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL sb_pop: got op=%0h txn=%0h addr=%0h, want op=%0h txn=%0h addr=%0h",
                   a.op, a.txn, a.addr, e.op, e.txn, e.addr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < 12 && tb_crd < 4; i++) step();
    step();
    total++;
    if (tb_crd !== 4) begin bad++; $display("FAIL crd_settle: got %0d want 4", tb_crd); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if ({rxreq_lcrdv, rxreq_valid, rxreq_err} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl: got lcrdv/valid/err=%b want 000", {rxreq_lcrdv, rxreq_valid, rxreq_err});
    end
    total++;
    if ({rxreq_opcode, rxreq_txnid, rxreq_addr} !== '0 || dut.crd_out_q !== 4'd0 || dut.fifo_cnt_q !== 4'd0) begin
      bad++; $display("FAIL reset_state: got op=%0h txn=%0h crd=%0d cnt=%0d want 0", rxreq_opcode,
                      rxreq_txnid, dut.crd_out_q, dut.fifo_cnt_q);
    end
  endtask

  task automatic test_credit_ramp();
    logic exp_l;
    rst = 1'b0;
    tb_crd = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_l = (i < 4);
      total++;
      if (rxreq_lcrdv !== exp_l) begin
        bad++; $display("FAIL ramp_lcrdv[%0d]: got %b want %b", i, rxreq_lcrdv, exp_l);
      end
    end
    total++;
    if (dut.crd_out_q !== 4'd4 || tb_crd !== 4) begin
      bad++; $display("FAIL ramp_crd: got crd_out=%0d counted=%0d want 4", dut.crd_out_q, tb_crd);
    end
  endtask

  task automatic test_single();
    rxreq_ready = 1'b0;
    drive_flit(7'h04, 12'h012, 52'h1000);
    step();
    rxreqflitv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rxreq_valid !== 1'b1 || rxreq_opcode !== 7'h04 || rxreq_txnid !== 12'h012 || rxreq_addr !== 52'h1000) begin
        bad++; $display("FAIL single_hold[%0d]: got v=%b op=%0h txn=%0h addr=%0h want 1/04/12/1000",
                        i, rxreq_valid, rxreq_opcode, rxreq_txnid, rxreq_addr);
      end
      if (i < 2) step();
    end
    rxreq_ready = 1'b1;
    step();
    rxreq_ready = 1'b0;
    total++;
    if (rxreq_valid !== 1'b0 || rxreq_lcrdv !== 1'b0) begin
      bad++; $display("FAIL single_pop: got valid=%b lcrdv=%b want 0 0", rxreq_valid, rxreq_lcrdv);
    end
    step();
    total++;
    if (rxreq_lcrdv !== 1'b1) begin bad++; $display("FAIL single_regrant: got lcrdv=%b want 1", rxreq_lcrdv); end
  endtask

  task automatic test_fill_stream();
    int highs = 0, nxt = 4, pops0, err0, cyc = 0;
    settle();
    rxreq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_flit(7'h04, 12'(i), 52'h2000 + 52'(i * 64));
      step();
    end
    rxreqflitv = 1'b0;
    total++;
    if (dut.fifo_cnt_q !== 4'd4 || rxreq_valid !== 1'b1 || rxreq_txnid !== 12'h000) begin
      bad++; $display("FAIL fill_full: got cnt=%0d valid=%b txn=%0h want 4 1 0", dut.fifo_cnt_q, rxreq_valid, rxreq_txnid);
    end
    for (int i = 0; i < 4; i++) begin
      if (rxreq_lcrdv === 1'b1) highs++;
      step();
    end
    total++;
    if (highs !== 0) begin bad++; $display("FAIL fill_nogrant: got %0d grants want 0", highs); end
    pops0 = pops;
    err0 = err_seen;
    rxreq_ready = 1'b1;
    while (cyc < 60 && (nxt < 8 || sb.size() != 0)) begin
      if (tb_crd > 0 && nxt < 8) begin
        drive_flit(7'h04, 12'(nxt), 52'h2000 + 52'(nxt * 64));
        nxt++;
      end else rxreqflitv = 1'b0;
      step();
      cyc++;
    end
    rxreqflitv = 1'b0;
    rxreq_ready = 1'b0;
    total++;
    if (sb.size() != 0 || pops - pops0 !== 8 || nxt !== 8) begin
      bad++; $display("FAIL stream_done: got pops=%0d pending=%0d sent_to=%0d want 8 0 8", pops - pops0, sb.size(), nxt);
    end
    total++;
    if (err_seen !== err0) begin bad++; $display("FAIL stream_err: got %0d errs want 0", err_seen - err0); end
  endtask

  task automatic test_credit_return();
    settle();
    drive_flit(7'h00, 12'h03F, 52'h0);
    step();
    rxreqflitv = 1'b0;
    total++;
    if (rxreq_valid !== 1'b0 || dut.crd_out_q !== 4'd3 || rxreq_lcrdv !== 1'b0) begin
      bad++; $display("FAIL crdret_absorb: got valid=%b crd=%0d lcrdv=%b want 0 3 0", rxreq_valid, dut.crd_out_q, rxreq_lcrdv);
    end
    step();
    total++;
    if (rxreq_lcrdv !== 1'b1 || rxreq_valid !== 1'b0) begin
      bad++; $display("FAIL crdret_regrant: got lcrdv=%b valid=%b want 1 0", rxreq_lcrdv, rxreq_valid);
    end
    step();
    total++;
    if (rxreq_lcrdv !== 1'b0 || dut.crd_out_q !== 4'd4) begin
      bad++; $display("FAIL crdret_once: got lcrdv=%b crd=%0d want 0 4", rxreq_lcrdv, dut.crd_out_q);
    end
  endtask

  task automatic test_protocol_error();
    rst = 1'b1;
    step(); step();
    sb.delete();
    tb_crd = 0;
    rst = 1'b0;
    rxreqflitv = 1'b1;
    rxreqflit = mk_flit(7'h04, 12'h055, 52'h3000);
    step();
    rxreqflitv = 1'b0;
    total++;
    if (rxreq_err !== 1'b1 || rxreq_valid !== 1'b0) begin
      bad++; $display("FAIL perr_pulse: got err=%b valid=%b want 1 0", rxreq_err, rxreq_valid);
    end
    total++;
    if (dut.fifo_cnt_q !== 4'd0 || dut.crd_out_q !== 4'd1) begin
      bad++; $display("FAIL perr_counters: got cnt=%0d crd=%0d want 0 1", dut.fifo_cnt_q, dut.crd_out_q);
    end
    step();
    total++;
    if (rxreq_err !== 1'b0) begin bad++; $display("FAIL perr_onecycle: got err=%b want 0", rxreq_err); end
  endtask

  task automatic test_reset_midop();
    int highs = 0;
    logic first;
    settle();
    rxreq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_flit(7'h04, 12'h0A0 + 12'(i), 52'h4000 + 52'(i));
      step();
    end
    rxreqflitv = 1'b0;
    total++;
    if (rxreq_valid !== 1'b1 || dut.fifo_cnt_q !== 4'd3) begin
      bad++; $display("FAIL midop_fill: got valid=%b cnt=%0d want 1 3", rxreq_valid, dut.fifo_cnt_q);
    end
    rst = 1'b1;
    step();
    total++;
    if (rxreq_valid !== 1'b0 || {rxreq_opcode, rxreq_txnid, rxreq_addr} !== '0 || rxreq_lcrdv !== 1'b0 ||
        dut.crd_out_q !== 4'd0) begin
      bad++; $display("FAIL midop_clear: got valid=%b op=%0h txn=%0h lcrdv=%b crd=%0d want all 0",
                      rxreq_valid, rxreq_opcode, rxreq_txnid, rxreq_lcrdv, dut.crd_out_q);
    end
    sb.delete();
    tb_crd = 0;
    rst = 1'b0;
    step();
    first = rxreq_lcrdv;
    for (int i = 0; i < 7; i++) begin
      if (rxreq_lcrdv === 1'b1) highs++;
      step();
    end
    total++;
    if (first !== 1'b1 || highs !== 4) begin
      bad++; $display("FAIL midop_ramp: got first=%b grants=%0d want 1 4", first, highs);
    end
  endtask

  initial begin
    test_reset();
    test_credit_ramp();
    test_single();
    test_fill_stream();
    test_credit_return();
    test_protocol_error();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
